// File: rtl/seq_detect_param.sv
// seq_detect_param: serial sequence detector against a runtime-loadable
// PAT_W-bit pattern. Supports overlapping / non-overlapping detection, a
// din_valid qualifier for gaps in the stream, a same-cycle (Mealy) match and
// a registered match_q.
//
// Optional feature macro: SEQDET_MATCH_CNT_EN
//   defined   -> saturating match counter driven on match_cnt, cleared by cnt_clr
//   undefined -> no counter flops, match_cnt tied to 0, cnt_clr ignored
//
// Input qualifier: din is consumed on a rising edge only when din_valid is
// high and pat_load is low. There is no backpressure; the block always accepts.
module seq_detect_param #(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PAT_RST = PAT_W'(4'b1010),
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_cnt
);

    // fill only needs to reach PAT_W-1, which fits in clog2(PAT_W) bits
    localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  pat;
    logic [PAT_W-1:0]  window;
    logic              accept;

    // A pattern load steals the cycle: din is dropped and no match is possible
    assign accept = din_valid & ~pat_load;
    assign window = {hist, din};
    assign match  = accept & (fill == FILL_FULL) & (window == pat);

    // History, fill level and pattern register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
            pat  <= PAT_RST;
        end else if (pat_load) begin
            pat  <= pat_in;
            fill <= '0;
        end else if (din_valid) begin
            // newest bit enters the LSB; oldest bit of the window falls off
            hist <= window[PAT_W-2:0];
            if (match && !overlap) begin
                // matched bits are consumed and cannot start the next match
                fill <= '0;
            end else if (fill != FILL_FULL) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    // Registered copy of the Mealy match
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match;
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating match counter; a clear coinciding with a match leaves 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= match ? CNT_W'(1) : '0;
        end else if (match && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_cnt = cnt;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param (PAT_W=4, CNT_W=2). Expected match
// values are hand-derived per stimulus bit; counter expectations depend on
// whether SEQDET_MATCH_CNT_EN is defined for the build.
module tb_seq_detect_param;

`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       cnt_clr;
    logic       match;
    logic       match_q;
    logic [1:0] match_cnt;

    int n_checks;
    int n_fail;

    seq_detect_param #(
        .PAT_W   (4),
        .PAT_RST (4'b1010),
        .CNT_W   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .cnt_clr   (cnt_clr),
        .match     (match),
        .match_q   (match_q),
        .match_cnt (match_cnt)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int v);
        return CNT_ON ? 32'(v) : 32'd0;
    endfunction

    // One clock of stimulus: drive at negedge, check Mealy match mid-cycle,
    // check match_q just after the rising edge.
    task automatic send(input logic b, input logic v, input logic load, input logic clr,
                        input logic exp, input string tag);
        @(negedge clk);
        din       = b;
        din_valid = v;
        pat_load  = load;
        cnt_clr   = clr;
        #1;
        check({tag, " match"}, match, exp);
        @(posedge clk);
        #1;
        check({tag, " match_q"}, match_q, exp);
        din_valid = 1'b0;
        pat_load  = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    // Send n valid bits, MSB of bits first; exps gives the expected match per bit
    task automatic stream(input logic [15:0] bits, input logic [15:0] exps, input int n,
                          input string tag);
        for (int i = 0; i < n; i++) begin
            send(bits[n-1-i], 1'b1, 1'b0, 1'b0, exps[n-1-i], $sformatf("%s b%0d", tag, i + 1));
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, " rst match"}, match, 1'b0);
        check({tag, " rst match_q"}, match_q, 1'b0);
        check({tag, " rst cnt"}, match_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        overlap   = 1'b1;
        pat_load  = 1'b0;
        pat_in    = 4'b0000;
        cnt_clr   = 1'b0;

        // Reset state
        #2;
        check("por match_q", match_q, 1'b0);
        check("por cnt", match_cnt, 32'd0);
        check("por match", match, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Overlapping: 101010 -> matches on bits 4 and 6
        overlap = 1'b1;
        stream(16'b101010, 16'b000101, 6, "ovl");
        check("ovl cnt", match_cnt, cnt_exp(2));

        // Non-overlapping: 10101010 -> matches on bits 4 and 8
        do_reset("nov");
        overlap = 1'b0;
        stream(16'b10101010, 16'b00010001, 8, "nov");
        check("nov cnt", match_cnt, cnt_exp(2));

        // Gaps: three invalid cycles (with misleading din) between valid bits
        do_reset("gap");
        overlap = 1'b1;
        begin
            logic [3:0] gbits;
            gbits = 4'b1010;
            for (int i = 0; i < 4; i++) begin
                send(gbits[3-i], 1'b1, 1'b0, 1'b0, (i == 3), $sformatf("gap v%0d", i + 1));
                if (i < 3) begin
                    for (int j = 0; j < 3; j++) begin
                        send(~gbits[3-i], 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("gap idle%0d_%0d", i + 1, j));
                    end
                end
            end
        end
        check("gap cnt", match_cnt, cnt_exp(1));

        // Pattern load mid-stream; din=0 would complete 1010 if not dropped
        do_reset("pld");
        overlap = 1'b0;
        stream(16'b101, 16'b000, 3, "pld pre");
        pat_in = 4'b1101;
        send(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "pld load");
        stream(16'b1101, 16'b0001, 4, "pld new");
        stream(16'b1010, 16'b0000, 4, "pld old");

        // Async reset: match_q and count drop immediately, no clock edge needed
        do_reset("ars");
        overlap = 1'b1;
        stream(16'b1010, 16'b0001, 4, "ars a");
        #1;
        rst = 1'b0;
        #1;
        check("ars async match_q", match_q, 1'b0);
        check("ars async cnt", match_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        // Partial 1,0,1 then reset: final 0 must not complete the pattern
        stream(16'b101, 16'b000, 3, "ars b");
        do_reset("ars mid");
        stream(16'b0, 16'b0, 1, "ars c");
        check("ars c cnt", match_cnt, 32'd0);

        // Counter saturation at 3 with five overlapping matches
        do_reset("sat");
        overlap = 1'b1;
        stream(16'b1010, 16'b0001, 4, "sat m1");
        check("sat cnt1", match_cnt, cnt_exp(1));
        stream(16'b10, 16'b01, 2, "sat m2");
        check("sat cnt2", match_cnt, cnt_exp(2));
        stream(16'b10, 16'b01, 2, "sat m3");
        check("sat cnt3", match_cnt, cnt_exp(3));
        stream(16'b1010, 16'b0101, 4, "sat m45");
        check("sat cnt stuck", match_cnt, cnt_exp(3));
        // Clear alone
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr alone");
        check("clr alone cnt", match_cnt, 32'd0);
        // Clear coinciding with a match
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "clr pre");
        send(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "clr match");
        check("clr match cnt", match_cnt, cnt_exp(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
